// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit register with hold, parallel load,
// shift, rotate and optional increment/decrement. All state changes happen
// on the falling edge of CLK; reset R is synchronous and active-high.
// Optional feature macro: USR_ARITH_EN enables MODE 110 (increment) and
// MODE 111 (decrement). Without it, those modes hold and no adder exists.
module universal_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_,
    output logic             SOUT,
    output logic             ZF
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
`ifdef USR_ARITH_EN
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;
`endif

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             sout_q;
    logic             sout_d;

`ifdef USR_ARITH_EN
    // The extra top bit of each result is the carry/borrow; it feeds only SOUT.
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_diff;

    // WIDTH+1-bit add/subtract so wraparound shows up in the top bit
    always_comb begin
        inc_sum  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
        dec_diff = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
    end
`endif

    // Next-state selection: EN gates everything, then MODE picks the operation
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (EN) begin
            case (MODE)
                MODE_HOLD: begin
                    q_d    = q_q;
                    sout_d = sout_q;
                end
                MODE_LOAD: begin
                    q_d = D;
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], SIN};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {SIN, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
`ifdef USR_ARITH_EN
                MODE_INC: begin
                    q_d    = inc_sum[WIDTH-1:0];
                    sout_d = inc_sum[WIDTH];
                end
                MODE_DEC: begin
                    q_d    = dec_diff[WIDTH-1:0];
                    sout_d = dec_diff[WIDTH];
                end
`endif
                // Arithmetic modes fall here when the feature is compiled out
                default: begin
                    q_d    = q_q;
                    sout_d = sout_q;
                end
            endcase
        end
    end

    // Falling-edge state register; synchronous reset overrides EN and MODE
    always_ff @(negedge CLK) begin
        if (R) begin
            q_q    <= RESET_VALUE;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    // Outputs derived purely from the stored value
    always_comb begin
        Q    = q_q;
        Q_   = ~q_q;
        SOUT = sout_q;
        ZF   = (q_q == '0);
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed vector table,
// hand-written multi-cycle sequences, WIDTH=2/32 shift checks and a random
// run against an arithmetic reference model. Honours USR_ARITH_EN.
module tb_universal_shift_register;

    logic CLK = 1'b1;
    always #5 CLK = ~CLK;

    // 8-bit instance, RESET_VALUE = 8'h5A
    logic       r, en, sin, sout, zf;
    logic [2:0] mode;
    logic [7:0] d, q, qn;

    universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut (
        .CLK(CLK), .R(r), .EN(en), .MODE(mode), .D(d), .SIN(sin),
        .Q(q), .Q_(qn), .SOUT(sout), .ZF(zf)
    );

    // 2-bit instance
    logic       r2, en2, sin2, sout2, zf2;
    logic [2:0] mode2;
    logic [1:0] d2, q2, qn2;

    universal_shift_register #(.WIDTH(2), .RESET_VALUE(2'b00)) dut2 (
        .CLK(CLK), .R(r2), .EN(en2), .MODE(mode2), .D(d2), .SIN(sin2),
        .Q(q2), .Q_(qn2), .SOUT(sout2), .ZF(zf2)
    );

    // 32-bit instance
    logic        r32, en32, sin32, sout32, zf32;
    logic [2:0]  mode32;
    logic [31:0] d32, q32, qn32;

    universal_shift_register #(.WIDTH(32), .RESET_VALUE(32'h0)) dut32 (
        .CLK(CLK), .R(r32), .EN(en32), .MODE(mode32), .D(d32), .SIN(sin32),
        .Q(q32), .Q_(qn32), .SOUT(sout32), .ZF(zf32)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive the 8-bit instance, let one falling edge pass, settle
    task automatic step(input logic rr, input logic ee, input logic [2:0] mm,
                        input logic [7:0] dd, input logic ss);
        r = rr; en = ee; mode = mm; d = dd; sin = ss;
        @(negedge CLK);
        #1;
    endtask

    // Reference model: value held as an integer, operations as arithmetic
    longint m_q;
    logic   m_sout;

    task automatic mstep(input logic rr, input logic ee, input logic [2:0] mm,
                         input logic [7:0] dd, input logic ss);
        longint M;
        longint qv;
        longint sv;
        M  = 256;
        qv = m_q;
        sv = ss ? 1 : 0;
        if (rr) begin
            m_q = 'h5A; m_sout = 1'b0;
        end else if (ee) begin
            case (mm)
                3'd1: m_q = longint'(dd);
                3'd2: begin m_sout = (qv >= M/2); m_q = (qv*2 + sv) % M; end
                3'd3: begin m_sout = (qv % 2 == 1); m_q = qv/2 + sv*(M/2); end
                3'd4: begin m_sout = (qv >= M/2); m_q = (qv*2) % M + qv/(M/2); end
                3'd5: begin m_sout = (qv % 2 == 1); m_q = qv/2 + (qv % 2)*(M/2); end
`ifdef USR_ARITH_EN
                3'd6: begin m_sout = (qv == M-1); m_q = (qv + 1) % M; end
                3'd7: begin m_sout = (qv == 0); m_q = (qv + M - 1) % M; end
`endif
                default: ;
            endcase
        end
    endtask

    typedef struct {
        string      nm;
        logic       r;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic       es;
    } vec_t;

    vec_t tbl[14];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] nq;
        logic [7:0] held;
        logic [7:0] a_inc_q, a_dec1_q, a_dec2_q;
        logic       a_inc_s, a_dec1_s, a_dec2_s;

`ifdef USR_ARITH_EN
        a_inc_q  = 8'h00; a_inc_s  = 1'b1;
        a_dec1_q = 8'hFF; a_dec1_s = 1'b1;
        a_dec2_q = 8'hFE; a_dec2_s = 1'b0;
`else
        a_inc_q  = 8'hFF; a_inc_s  = 1'b1;
        a_dec1_q = 8'hFF; a_dec1_s = 1'b1;
        a_dec2_q = 8'hFF; a_dec2_s = 1'b1;
`endif

        tbl[0]  = '{"rst_over_load", 1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 8'h5A, 1'b0};
        tbl[1]  = '{"load_c3",       1'b0, 1'b1, 3'b001, 8'hC3, 1'b0, 8'hC3, 1'b0};
        tbl[2]  = '{"en0_hold",      1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 8'hC3, 1'b0};
        tbl[3]  = '{"mode_hold",     1'b0, 1'b1, 3'b000, 8'h11, 1'b1, 8'hC3, 1'b0};
        tbl[4]  = '{"load_81",       1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 8'h81, 1'b0};
        tbl[5]  = '{"shl_sin0",      1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 8'h02, 1'b1};
        tbl[6]  = '{"shr_sin1",      1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 8'h81, 1'b0};
        tbl[7]  = '{"rol",           1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 8'h03, 1'b1};
        tbl[8]  = '{"ror",           1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 8'h81, 1'b1};
        tbl[9]  = '{"load_ff",       1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 8'hFF, 1'b1};
        tbl[10] = '{"inc_wrap",      1'b0, 1'b1, 3'b110, 8'h00, 1'b0, a_inc_q,  a_inc_s};
        tbl[11] = '{"dec_wrap",      1'b0, 1'b1, 3'b111, 8'h00, 1'b0, a_dec1_q, a_dec1_s};
        tbl[12] = '{"dec_plain",     1'b0, 1'b1, 3'b111, 8'h00, 1'b0, a_dec2_q, a_dec2_s};
        tbl[13] = '{"rst_en0",       1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 8'h5A, 1'b0};

        r = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0;
        r2 = 1'b0; en2 = 1'b0; mode2 = 3'b000; d2 = 2'b00; sin2 = 1'b0;
        r32 = 1'b0; en32 = 1'b0; mode32 = 3'b000; d32 = 32'h0; sin32 = 1'b0;
        #1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin);
            nq = ~tbl[i].eq;
            chk({tbl[i].nm, "_q"},    q,    tbl[i].eq);
            chk({tbl[i].nm, "_qn"},   qn,   nq);
            chk({tbl[i].nm, "_sout"}, sout, tbl[i].es);
            chk({tbl[i].nm, "_zf"},   zf,   (tbl[i].eq == 8'h00));
        end

        // Rotate right eight times returns to the start value
        step(1'b0, 1'b1, 3'b001, 8'h81, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'b101, 8'h00, 1'b0);
            if (i == 0) chk("ror8_first", q, 8'hC0);
        end
        chk("ror8_final", q, 8'h81);

        // Reset pulse that never meets a falling edge has no effect
        step(1'b0, 1'b1, 3'b001, 8'h3C, 1'b0);
        held = q;
        mode = 3'b000;
        #1 r = 1'b1;
        #2 r = 1'b0;
        chk("rpulse_now", q, held);
        @(negedge CLK); #1;
        chk("rpulse_edge", q, held);

        // Reset asserted mid shift sequence abandons it
        step(1'b0, 1'b1, 3'b010, 8'h00, 1'b1);
        step(1'b1, 1'b1, 3'b010, 8'h00, 1'b1);
        chk("rst_mid_shift_q", q, 8'h5A);
        chk("rst_mid_shift_sout", sout, 1'b0);
        step(1'b0, 1'b1, 3'b010, 8'h00, 1'b1);
        chk("after_release_q", q, 8'hB5);
        chk("after_release_sout", sout, 1'b0);

        // WIDTH=2 and WIDTH=32: shift ones in from all-zero
        r2 = 1'b1; en2 = 1'b1; mode2 = 3'b010; sin2 = 1'b1;
        r32 = 1'b1; en32 = 1'b1; mode32 = 3'b010; sin32 = 1'b1;
        @(negedge CLK); #1;
        chk("w2_rst_q", q2, 2'b00);
        chk("w2_rst_zf", zf2, 1'b1);
        chk("w32_rst_q", q32, 32'h0);
        chk("w32_rst_zf", zf32, 1'b1);
        r2 = 1'b0; r32 = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK); #1;
            if (i == 1) chk("w2_shl1", q2, 2'b01);
            if (i == 2) begin
                chk("w2_ones_q", q2, 2'b11);
                chk("w2_ones_qn", qn2, 2'b00);
                chk("w2_sout", sout2, 1'b0);
                en2 = 1'b0;
            end
            if (i == 16) chk("w32_half", q32, 32'h0000FFFF);
        end
        chk("w32_ones_q", q32, 32'hFFFFFFFF);
        chk("w32_ones_qn", qn32, 32'h0);
        chk("w32_zf", zf32, 1'b0);
        chk("w2_held", q2, 2'b11);
        en32 = 1'b0;

        // Randomized run against the reference model
        step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
        m_q = 'h5A; m_sout = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic       rr, ee, ss;
            logic [2:0] mm;
            logic [7:0] dd;
            rr = ($urandom_range(0, 19) == 0);
            ee = ($urandom_range(0, 7) != 0);
            mm = 3'($urandom_range(0, 7));
            dd = 8'($urandom);
            ss = 1'($urandom);
            if (i % 64 == 10) begin mm = 3'b001; dd = 8'hFF; ee = 1'b1; rr = 1'b0; end
            if (i % 64 == 11) begin mm = 3'b110; ee = 1'b1; rr = 1'b0; end
            if (i % 64 == 12) begin mm = 3'b111; ee = 1'b1; rr = 1'b0; end
            step(rr, ee, mm, dd, ss);
            mstep(rr, ee, mm, dd, ss);
            chk("rand_q", q, m_q);
            chk("rand_sout", sout, m_sout);
            chk("rand_zf", zf, (m_q == 0));
            nq = ~q;
            chk("rand_qn", qn, nq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
